// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag SRAM sequencer: clears all tags after reset/flush, arbitrates the
// single RW port between fill writes and lookup reads, and keeps hit/miss counters.
module icache_tag_ctrl #(
  parameter int unsigned SET_BITS    = 5,
  parameter int unsigned OFFSET_BITS = 5,
  parameter int unsigned TAG_BITS    = 22,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_addr,
  output logic                 lookup_ready,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [SET_BITS-1:0]  resp_set,
  input  logic                 fill_valid,
  input  logic [31:0]          fill_addr,
  output logic                 fill_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic                 tag_csb0,
  output logic                 tag_web0,
  output logic [SET_BITS-1:0]  tag_addr0,
  output logic [TAG_BITS:0]    tag_din0,
  input  logic [TAG_BITS:0]    tag_dout0
);

  localparam int unsigned TAG_LO = OFFSET_BITS + SET_BITS;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state, state_next;
  logic [SET_BITS-1:0] clr_idx;
  logic [TAG_BITS-1:0] tag_q;
  logic [SET_BITS-1:0] set_q;
  logic                lookup_take;

  logic [SET_BITS-1:0] lookup_set, fill_set;
  logic [TAG_BITS-1:0] lookup_tag, fill_tag;
  logic                unused_offset_bits;

  assign lookup_set = lookup_addr[TAG_LO-1:OFFSET_BITS];
  assign lookup_tag = lookup_addr[31:TAG_LO];
  assign fill_set   = fill_addr[TAG_LO-1:OFFSET_BITS];
  assign fill_tag   = fill_addr[31:TAG_LO];
  assign unused_offset_bits = &{1'b0, lookup_addr[OFFSET_BITS-1:0], fill_addr[OFFSET_BITS-1:0]};

  assign busy        = (state == S_CLEAR);
  assign lookup_take = lookup_ready & lookup_valid;
  assign resp_set    = set_q;
  // Gated by resp_valid so the hit flag reads 0 in reset and between responses.
  assign resp_hit    = resp_valid & tag_dout0[TAG_BITS] & (tag_dout0[TAG_BITS-1:0] == tag_q);

  always_comb begin
    state_next   = state;
    tag_csb0     = 1'b1;
    tag_web0     = 1'b1;
    tag_addr0    = '0;
    tag_din0     = '0;
    lookup_ready = 1'b0;
    fill_ready   = 1'b0;
    case (state)
      S_CLEAR: begin
        if (!flush) begin
          tag_csb0  = 1'b0;
          tag_web0  = 1'b0;
          tag_addr0 = clr_idx;
          if (clr_idx == '1) state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_next = S_CLEAR;
        end else if (fill_valid) begin
          fill_ready = 1'b1;
          tag_csb0   = 1'b0;
          tag_web0   = 1'b0;
          tag_addr0  = fill_set;
          tag_din0   = {1'b1, fill_tag};
        end else begin
          lookup_ready = 1'b1;
          if (lookup_valid) begin
            tag_csb0  = 1'b0;
            tag_addr0 = lookup_set;
          end
        end
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (flush)
        clr_idx <= '0;
      else if (state == S_CLEAR)
        clr_idx <= clr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      tag_q      <= '0;
      set_q      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= lookup_take;
      if (lookup_take) begin
        tag_q <= lookup_tag;
        set_q <= lookup_set;
      end
      if (resp_valid) begin
        if (resp_hit) hit_count  <= hit_count + 1'b1;
        else          miss_count <= miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Scoreboard bench for icache_tag_ctrl with a behavioural tag SRAM and a tag-array model.
module tb_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic        lookup_ready;
  logic        resp_valid, resp_hit;
  logic [4:0]  resp_set;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_addr = '0;
  logic        fill_ready, busy;
  logic [31:0] hit_count, miss_count;
  logic        tag_csb0, tag_web0;
  logic [4:0]  tag_addr0;
  logic [22:0] tag_din0;
  logic [22:0] tag_dout0;

  icache_tag_ctrl #(.SET_BITS(5), .OFFSET_BITS(5), .TAG_BITS(22), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_ready(lookup_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_set(resp_set),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_ready(fill_ready),
    .busy(busy), .hit_count(hit_count), .miss_count(miss_count),
    .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
    .tag_din0(tag_din0), .tag_dout0(tag_dout0)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM, powered up with valid garbage so a missed clear shows as a hit
  logic [22:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {1'b1, 22'(i * 4)};
    tag_dout0 = '0;
  end
  always @(posedge clk) begin
    if (!tag_csb0) begin
      if (!tag_web0) mem[tag_addr0] <= tag_din0;
      else           tag_dout0 <= mem[tag_addr0];
    end
  end

  typedef struct packed { logic [4:0] set; logic hit; } exp_t;
  exp_t exp_q[$];

  logic [21:0] model_tag [32];
  logic        model_v   [32];
  int unsigned exp_hits = 0, exp_misses = 0;
  int unsigned checks = 0, failures = 0;

  logic        s_lr, s_fr, s_busy, s_csb, s_web;
  logic [4:0]  s_addr;
  logic [22:0] s_din;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin model_v[i] = 1'b0; model_tag[i] = '0; end
  endtask

  task automatic run_cycle(input logic fl, input logic fv, input logic [31:0] fa,
                           input logic lv, input logic [31:0] la);
    exp_t e;
    flush = fl; fill_valid = fv; fill_addr = fa; lookup_valid = lv; lookup_addr = la;
    #1;
    s_lr = lookup_ready; s_fr = fill_ready; s_busy = busy;
    s_csb = tag_csb0; s_web = tag_web0; s_addr = tag_addr0; s_din = tag_din0;
    if (resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("resp_set", 64'(resp_set), 64'(e.set));
        check("resp_hit", 64'(resp_hit), 64'(e.hit));
        if (e.hit) exp_hits++; else exp_misses++;
      end
    end
    if (lv && lookup_ready) begin
      e.set = la[9:5];
      e.hit = model_v[la[9:5]] && (model_tag[la[9:5]] == la[31:10]);
      exp_q.push_back(e);
    end
    if (fv && fill_ready) begin
      model_v[fa[9:5]] = 1'b1;
      model_tag[fa[9:5]] = fa[31:10];
    end
    if (fl) model_clear();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(); run_cycle(1'b0, 1'b0, '0, 1'b0, '0); endtask
  task automatic lookup(input logic [31:0] a); run_cycle(1'b0, 1'b0, '0, 1'b1, a); endtask
  task automatic fill(input logic [31:0] a); run_cycle(1'b0, 1'b1, a, 1'b0, '0); endtask

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, 64'(hit_count), 64'(exp_hits));
    check({tag, "_misses"}, 64'(miss_count), 64'(exp_misses));
  endtask

  task automatic sweep(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      idle();
      check("clr_busy", 64'(s_busy), 64'd1);
      check("clr_csb", 64'(s_csb), 64'd0);
      check("clr_web", 64'(s_web), 64'd0);
      check("clr_addr", 64'(s_addr), 64'(i));
      check("clr_din", 64'(s_din), 64'd0);
      check("clr_lr", 64'(s_lr), 64'd0);
    end
  endtask

  task automatic after_sweep();
    #1;
    check("run_busy", 64'(busy), 64'd0);
    check("run_lr", 64'(lookup_ready), 64'd1);
  endtask

  initial begin
    model_clear();
    #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_lr", 64'(lookup_ready), 64'd0);
    check("rst_fr", 64'(fill_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sweep(32);
    after_sweep();

    // single miss
    lookup(32'h0000_1040);
    idle();
    check_counts("first_miss");
    check("first_miss_cnt", 64'(miss_count), 64'd1);

    // fill then back-to-back lookups
    fill(32'h0000_1040);
    lookup(32'h0000_1044);
    lookup(32'h0000_2040);
    idle();
    check_counts("b2b");
    check("b2b_hit_cnt", 64'(hit_count), 64'd1);
    check("b2b_miss_cnt", 64'(miss_count), 64'd2);

    // fill and lookup together: fill wins
    run_cycle(1'b0, 1'b1, 32'h0000_3060, 1'b1, 32'h0000_3060);
    check("coll_fr", 64'(s_fr), 64'd1);
    check("coll_lr", 64'(s_lr), 64'd0);
    lookup(32'h0000_3060);
    check("coll_next_lr", 64'(s_lr), 64'd1);
    idle();

    // lookup pending while a fill to the same set lands: old contents
    lookup(32'h0004_3060);
    fill(32'h0004_3060);
    lookup(32'h0004_3060);
    idle();
    check_counts("fill_race");

    // four fills, flush right after a lookup issue
    fill(32'h0001_0000);
    fill(32'h0001_0020);
    fill(32'h0001_0040);
    fill(32'h0002_0060);
    lookup(32'h0001_0020);
    run_cycle(1'b1, 1'b0, '0, 1'b0, '0);
    check("flush_csb", 64'(s_csb), 64'd1);
    check("flush_lr", 64'(s_lr), 64'd0);
    sweep(32);
    after_sweep();
    lookup(32'h0001_0000);
    lookup(32'h0001_0020);
    lookup(32'h0001_0040);
    lookup(32'h0002_0060);
    idle();
    check_counts("post_flush");

    // flush mid-sweep restarts from set 0
    fill(32'h0000_0000);
    run_cycle(1'b1, 1'b0, '0, 1'b0, '0);
    sweep(10);
    run_cycle(1'b1, 1'b0, '0, 1'b0, '0);
    check("reflush_csb", 64'(s_csb), 64'd1);
    sweep(32);
    after_sweep();
    lookup(32'h0000_0000);
    idle();
    check_counts("reflush");

    // reset with a response pending
    lookup(32'h0000_1040);
    rst = 1'b1;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_hits", 64'(hit_count), 64'd0);
    check("midrst_misses", 64'(miss_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    exp_q.delete();
    exp_hits = 0; exp_misses = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep(32);
    after_sweep();
    lookup(32'h0000_1040);
    idle();
    check_counts("after_rst");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
